// File: rtl/gpmc_wb_sequencer.sv
// gpmc_wb_sequencer
// Bridges an asynchronous GPMC chip-select window onto a single-master
// Wishbone bus clocked by clk_fpga. Each GPMC write (NWE rising edge) or
// read (NOE falling edge) becomes exactly one Wishbone cycle. Reads stall
// the GPMC through EM_WAIT0 until the slave acks or the timeout expires.
//
// Ports
//   clk_fpga, rst_fpga            clock, async active-high reset
//   EM_NCS6, EM_NWE, EM_NOE       GPMC strobes (active low, asynchronous)
//   EM_A, EM_NBE, EM_D_i          GPMC halfword address, byte enables, write data
//   EM_D_o, EM_D_oe, EM_WAIT0     GPMC read data, pad enable, ready
//   wb_*                          Wishbone master port
//   timeout_o                     one-cycle pulse per timed-out transaction
//   busy_o                        high whenever the FSM is not idle
//   dbg_state_o                   current FSM state
//
// Wishbone handshake: wb_cyc_o and wb_stb_o rise together and stay high,
// with address/data/select stable, until the cycle in which wb_ack_i is
// sampled high (transfer complete) or the timeout expires (transfer
// abandoned). wb_ack_i is ignored whenever no request is outstanding.
module gpmc_wb_sequencer #(
  parameter int          TIMEOUT     = 255,
  parameter logic [15:0] RD_ERR_DATA = 16'hDEAD
) (
  input  logic        clk_fpga,
  input  logic        rst_fpga,
  input  logic        EM_NCS6,
  input  logic        EM_NWE,
  input  logic        EM_NOE,
  input  logic [9:0]  EM_A,
  input  logic [1:0]  EM_NBE,
  input  logic [15:0] EM_D_i,
  output logic [15:0] EM_D_o,
  output logic        EM_D_oe,
  output logic        EM_WAIT0,
  output logic [10:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        timeout_o,
  output logic        busy_o,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_HOLD = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Last cycle a request may wait; the ack is still honoured in that cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  ncs_sync_q, ncs_sync_d;
  logic [2:0]  nwe_sync_q, nwe_sync_d;
  logic [2:0]  noe_sync_q, noe_sync_d;
  logic [1:0]  sync_prime_q, sync_prime_d;
  logic        nwe_armed_q, nwe_armed_d;
  logic        noe_armed_q, noe_armed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] adr_q, adr_d;
  logic [15:0] dat_q, dat_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;

  logic ncs_s, nwe_s, noe_s;
  logic nwe_rise, noe_fall, wr_start, rd_start;

  // Stage [1] is the synchronized level, stage [2] its previous value.
  assign ncs_s    = ncs_sync_q[1];
  assign nwe_s    = nwe_sync_q[1];
  assign noe_s    = noe_sync_q[1];
  assign nwe_rise = nwe_s & ~nwe_sync_q[2];
  assign noe_fall = ~noe_s & noe_sync_q[2];

  // A strobe is armed only once it has been seen high after reset, so a
  // strobe already asserted across reset cannot start a transaction.
  // sync_prime_q[1] marks when the synchronizers hold real pin samples
  // rather than their reset value.
  assign wr_start = nwe_rise & nwe_armed_q & ~ncs_s & noe_s;
  assign rd_start = noe_fall & noe_armed_q & ~ncs_s & nwe_s;

  always_ff @(posedge clk_fpga or posedge rst_fpga) begin
    if (rst_fpga) begin
      state_q      <= ST_IDLE;
      ncs_sync_q   <= 3'b111;
      nwe_sync_q   <= 3'b111;
      noe_sync_q   <= 3'b111;
      sync_prime_q <= 2'b00;
      nwe_armed_q  <= 1'b0;
      noe_armed_q  <= 1'b0;
      cnt_q        <= 8'd0;
      adr_q        <= 11'd0;
      dat_q        <= 16'd0;
      sel_q        <= 2'd0;
      rdata_q      <= 16'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ncs_sync_q   <= ncs_sync_d;
      nwe_sync_q   <= nwe_sync_d;
      noe_sync_q   <= noe_sync_d;
      sync_prime_q <= sync_prime_d;
      nwe_armed_q  <= nwe_armed_d;
      noe_armed_q  <= noe_armed_d;
      cnt_q        <= cnt_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rdata_q      <= rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    ncs_sync_d   = {ncs_sync_q[1:0], EM_NCS6};
    nwe_sync_d   = {nwe_sync_q[1:0], EM_NWE};
    noe_sync_d   = {noe_sync_q[1:0], EM_NOE};
    sync_prime_d = {sync_prime_q[0], 1'b1};
    nwe_armed_d  = nwe_armed_q | (nwe_s & sync_prime_q[1]);
    noe_armed_d  = noe_armed_q | (noe_s & sync_prime_q[1]);
    state_d      = state_q;
    cnt_d        = cnt_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rdata_d      = rdata_q;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_start) begin
          state_d = ST_WR_REQ;
          cnt_d   = 8'd0;
          adr_d   = {EM_A, 1'b0};
          dat_d   = EM_D_i;
          sel_d   = ~EM_NBE;
        end else if (rd_start) begin
          state_d = ST_RD_REQ;
          cnt_d   = 8'd0;
          adr_d   = {EM_A, 1'b0};
          sel_d   = ~EM_NBE;
        end
      end
      ST_WR_REQ: begin
        if (wb_ack_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RD_REQ: begin
        if (wb_ack_i) begin
          state_d = ST_RD_HOLD;
          rdata_d = wb_dat_i;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_RD_HOLD;
          rdata_d   = RD_ERR_DATA;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RD_HOLD: begin
        if (noe_s || ncs_s) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign wb_cyc_o    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign wb_stb_o    = wb_cyc_o;
  assign wb_we_o     = (state_q == ST_WR_REQ);
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign EM_D_o      = rdata_q;
  assign EM_D_oe     = (state_q == ST_RD_HOLD);
  assign EM_WAIT0    = (state_q != ST_RD_REQ);
  assign timeout_o   = timeout_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gpmc_wb_sequencer.sv
// Testbench for gpmc_wb_sequencer: directed scenarios followed by random
// GPMC reads/writes against a transaction-level reference model.
module tb_gpmc_wb_sequencer;

  localparam int TO = 8;
  localparam int W  = 30; // {we, adr[10:0], dat[15:0], sel[1:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        EM_NCS6 = 1'b1, EM_NWE = 1'b1, EM_NOE = 1'b1;
  logic [9:0]  EM_A = '0;
  logic [1:0]  EM_NBE = 2'b11;
  logic [15:0] EM_D_i = '0;
  logic [15:0] EM_D_o;
  logic        EM_D_oe, EM_WAIT0;
  logic [10:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        timeout_o, busy_o;
  logic [2:0]  dbg_state;

  gpmc_wb_sequencer #(.TIMEOUT(TO), .RD_ERR_DATA(16'hDEAD)) dut (
    .clk_fpga(clk), .rst_fpga(rst),
    .EM_NCS6(EM_NCS6), .EM_NWE(EM_NWE), .EM_NOE(EM_NOE),
    .EM_A(EM_A), .EM_NBE(EM_NBE), .EM_D_i(EM_D_i),
    .EM_D_o(EM_D_o), .EM_D_oe(EM_D_oe), .EM_WAIT0(EM_WAIT0),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .timeout_o(timeout_o), .busy_o(busy_o), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int exp_cyc = 0;
  int exp_to  = 0;
  int cyc_starts = 0;
  int to_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- Wishbone slave + monitors ----------------
  int          sl_delay = 0;
  logic [15:0] sl_rdata = '0;
  int          sl_cnt = 0;
  bit          ack_done = 0;
  logic        cyc_prev = 1'b0;

  always @(negedge clk) begin
    if (timeout_o) to_count++;
    if (wb_cyc_o && !cyc_prev) cyc_starts++;
    cyc_prev = wb_cyc_o;
    if (wb_cyc_o && wb_stb_o) begin
      if (!ack_done && sl_cnt == sl_delay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = sl_rdata;
        obs_q.push_back({wb_we_o, wb_adr_o, (wb_we_o ? wb_dat_o : 16'h0), wb_sel_o});
        ack_done = 1;
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
      end
      sl_cnt++;
    end else begin
      wb_ack_i = 1'b0;
      sl_cnt   = 0;
      ack_done = 0;
    end
  end

  task automatic scoreboard_check();
    logic [W-1:0] e, o;
    chk("timeout_pulses", to_count, exp_to);
    chk("wb_cycles", cyc_starts, exp_cyc);
    chk("wb_acked_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("wb_txn", {2'b00, o}, {2'b00, e});
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    chk(tag, busy_o, 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic gpmc_write(input logic [9:0] a, input logic [1:0] nbe,
                            input logic [15:0] d, input int delay);
    sl_delay = delay;
    @(posedge clk); #1;
    EM_NCS6 = 1'b0; EM_A = a; EM_NBE = nbe; EM_D_i = d;
    repeat (2) @(posedge clk);
    #1 EM_NWE = 1'b0;
    repeat ($urandom_range(2, 4)) @(posedge clk);
    #1 EM_NWE = 1'b1;
    exp_cyc++;
    if (delay < TO) exp_q.push_back({1'b1, a, 1'b0, d, ~nbe});
    else            exp_to++;
    repeat (5) @(posedge clk);
    #1 EM_NCS6 = 1'b1; EM_D_i = 16'($urandom);
    wait_idle("wr_idle");
    repeat (2) @(posedge clk);
    scoreboard_check();
  endtask

  task automatic gpmc_read(input logic [9:0] a, input logic [1:0] nbe,
                           input logic [15:0] d, input int delay);
    bit ok, prev_ack;
    bit success;
    logic [15:0] expd;
    success  = (delay < TO);
    expd     = success ? d : 16'hDEAD;
    sl_delay = delay;
    sl_rdata = d;
    @(posedge clk); #1;
    EM_NCS6 = 1'b0; EM_A = a; EM_NBE = nbe;
    repeat (2) @(posedge clk);
    #1 EM_NOE = 1'b0;
    exp_cyc++;
    if (success) exp_q.push_back({1'b0, a, 1'b0, 16'h0, ~nbe});
    else         exp_to++;
    ok = 0; prev_ack = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (!EM_WAIT0) begin ok = 1; prev_ack = wb_ack_i; break; end
    end
    chk("wait0_low", ok, 1'b1);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (EM_WAIT0) begin ok = 1; break; end
      prev_ack = wb_ack_i;
    end
    chk("wait0_high", ok, 1'b1);
    chk("ack_to_wait0", prev_ack, success);
    chk("rd_data", EM_D_o, expd);
    chk("d_oe_hold", EM_D_oe, 1'b1);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk); #1 EM_NOE = 1'b1;
    @(posedge clk); #1 EM_NCS6 = 1'b1;
    wait_idle("rd_idle");
    chk("d_oe_off", EM_D_oe, 1'b0);
    repeat (2) @(posedge clk);
    scoreboard_check();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_cyc"}, wb_cyc_o, 1'b0);
    chk({pfx, "_stb"}, wb_stb_o, 1'b0);
    chk({pfx, "_we"}, wb_we_o, 1'b0);
    chk({pfx, "_adr"}, wb_adr_o, 11'h0);
    chk({pfx, "_dat"}, wb_dat_o, 16'h0);
    chk({pfx, "_sel"}, wb_sel_o, 2'b00);
    chk({pfx, "_d_o"}, EM_D_o, 16'h0);
    chk({pfx, "_d_oe"}, EM_D_oe, 1'b0);
    chk({pfx, "_wait0"}, EM_WAIT0, 1'b1);
    chk({pfx, "_timeout"}, timeout_o, 1'b0);
    chk({pfx, "_busy"}, busy_o, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Directed write, read, timeout and boundary cases
    gpmc_write(10'h012, 2'b00, 16'hA5C3, 3);
    gpmc_read(10'h003, 2'b00, 16'h1234, 5);
    gpmc_read(10'h155, 2'b01, 16'h7777, 20);
    gpmc_read(10'h2AA, 2'b10, 16'hBEEF, TO - 1);
    gpmc_read(10'h0F0, 2'b00, 16'h4242, TO);
    gpmc_write(10'h3FF, 2'b10, 16'h0F0F, TO - 1);
    gpmc_write(10'h001, 2'b01, 16'h5A5A, TO + 3);

    // Second NWE pulse while the first write is still waiting for ack
    sl_delay = TO - 1;
    @(posedge clk); #1;
    EM_NCS6 = 1'b0; EM_A = 10'h0AB; EM_NBE = 2'b00; EM_D_i = 16'hC0DE;
    repeat (2) @(posedge clk);
    #1 EM_NWE = 1'b0;
    repeat (3) @(posedge clk);
    #1 EM_NWE = 1'b1;
    exp_cyc++;
    exp_q.push_back({1'b1, 10'h0AB, 1'b0, 16'hC0DE, 2'b11});
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb_cyc_o) begin ok = 1; break; end
    end
    chk("dup_first_cyc", ok, 1'b1);
    @(posedge clk); #1 EM_NWE = 1'b0;
    repeat (2) @(posedge clk);
    #1 EM_NWE = 1'b1;
    repeat (5) @(posedge clk);
    #1 EM_NCS6 = 1'b1;
    wait_idle("dup_idle");
    repeat (10) @(posedge clk);
    scoreboard_check();

    // Both strobes low together in IDLE: no transaction
    @(posedge clk); #1 EM_NCS6 = 1'b0; EM_NWE = 1'b0; EM_NOE = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("both_low_busy", busy_o, 1'b0);
    EM_NCS6 = 1'b1;
    repeat (3) @(posedge clk);
    #1 EM_NWE = 1'b1; EM_NOE = 1'b1;
    repeat (6) @(posedge clk);
    scoreboard_check();

    // Reset in RD_REQ with NOE held low
    sl_delay = 100;
    @(posedge clk); #1 EM_NCS6 = 1'b0; EM_A = 10'h077; EM_NBE = 2'b00;
    repeat (2) @(posedge clk);
    #1 EM_NOE = 1'b0;
    exp_cyc++;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb_cyc_o) begin ok = 1; break; end
    end
    chk("rst_rd_started", ok, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("no_read_after_rst", busy_o, 1'b0);
    scoreboard_check();
    EM_NOE = 1'b1;
    repeat (3) @(posedge clk);
    gpmc_read(10'h077, 2'b00, 16'h9ABC, 2);

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1)
        gpmc_write(10'($urandom), 2'($urandom), 16'($urandom), $urandom_range(0, 11));
      else
        gpmc_read(10'($urandom), 2'($urandom), 16'($urandom), $urandom_range(0, 11));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpmc_wb_sequencer.md
GPMC_WB_SEQUENCER -- requirements
Module: gpmc_wb_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max clk_fpga cycles waited for wb_ack_i (range 1-255).
REQ-002 SHALL have parameter RD_ERR_DATA, default 16'hDEAD: data returned on a timed-out read.
REQ-003 clk_fpga  in  1  sole clock; all logic on rising edge.
REQ-004 rst_fpga  in  1  asynchronous, active-high reset.
REQ-005 EM_NCS6  in  1  GPMC chip select, active low, asynchronous to clk_fpga.
REQ-006 EM_NWE, EM_NOE  in  1 each  GPMC write/output strobes, active low, asynchronous.
REQ-007 EM_A  in  10  halfword address [10:1]; EM_NBE  in  2  byte enables, active low.
REQ-008 EM_D_i  in  16  bus data in; EM_D_o  out  16  bus data out; EM_D_oe  out  1  pad drive enable.
REQ-009 EM_WAIT0  out  1  high = ready, low = read data not yet valid.
REQ-010 wb_adr_o  out  11  byte address {EM_A,1'b0}; wb_dat_o  out  16; wb_sel_o  out  2  = ~EM_NBE; wb_we_o, wb_stb_o, wb_cyc_o  out  1 each.
REQ-011 wb_dat_i  in  16; wb_ack_i  in  1.
REQ-012 timeout_o  out  1  one-cycle pulse per timed-out transaction; busy_o  out  1  high in any state except IDLE.

Function
REQ-013 SHALL pass EM_NCS6, EM_NWE, EM_NOE each through a 2-flop synchronizer plus a third flop for edge detection; bus fields are sampled only on detected edges.
REQ-014 Write start: synced NWE rising edge while synced NCS6 low; EM_A, EM_NBE, EM_D_i captured into wb_adr_o/wb_sel_o/wb_dat_o in that same cycle (GPMC write hold time SHALL be configured >= 4 clk_fpga cycles).
REQ-015 Read start: synced NOE falling edge while synced NCS6 low and synced NWE high; EM_A, EM_NBE captured; EM_WAIT0 driven low on the following cycle.
REQ-016 States: IDLE, WR_REQ, RD_REQ, RD_HOLD, DRAIN.
REQ-017 IDLE->WR_REQ on write start; IDLE->RD_REQ on read start; both strobes synced low in IDLE SHALL be ignored (stay IDLE).
REQ-018 WR_REQ/RD_REQ: wb_cyc_o=wb_stb_o=1, wb_we_o=1 only in WR_REQ; held until wb_ack_i or timeout.
REQ-019 WR_REQ + wb_ack_i -> IDLE, strobes drop next cycle; RD_REQ + wb_ack_i -> RD_HOLD, wb_dat_i latched into EM_D_o.
REQ-020 8-bit timeout counter cleared on entry to *_REQ, incremented each *_REQ cycle; reaching TIMEOUT without ack: drop cyc/stb, pulse timeout_o, WR_REQ->IDLE, RD_REQ->RD_HOLD with EM_D_o=RD_ERR_DATA.
REQ-021 wb_ack_i arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (no timeout_o, bus data used).
REQ-022 RD_HOLD: EM_D_oe=1, EM_WAIT0=1; exits to DRAIN when synced NOE high or synced NCS6 high; EM_D_oe drops on that transition.
REQ-023 DRAIN: one cycle with EM_D_oe=0, then IDLE; no new transaction accepted in DRAIN.
REQ-024 Strobe edges arriving in any non-IDLE state SHALL be dropped, not queued.
REQ-025 wb_ack_i outside WR_REQ/RD_REQ SHALL be ignored.
REQ-026 Latency: NWE rising at pin -> wb_stb_o high <= 4 clk_fpga cycles; wb_ack_i -> EM_WAIT0 high exactly 1 cycle.

Reset
REQ-027 On rst_fpga high, immediately: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0, EM_D_o=0, EM_D_oe=0, EM_WAIT0=1, timeout_o=0, busy_o=0, timeout counter 0, synchronizer flops to 1 (strobes inactive).
REQ-028 Reset asserted mid-transaction SHALL abort it with no Wishbone cycle outstanding; after release, a strobe already low SHALL NOT start a transaction until it deasserts and reasserts.

Verification
REQ-029 Write: NCS6=0, A=10'h012, NBE=2'b00, D=16'hA5C3, NWE pulse -> one WB write adr 11'h024, dat 16'hA5C3, sel 2'b11; ack after 3 cycles -> IDLE, busy_o low.
REQ-030 Read: A=10'h003, NOE low, slave acks with 16'h1234 after 5 cycles -> EM_WAIT0 low then high 1 cycle after ack, EM_D_o=16'h1234, EM_D_oe high until NOE high, then DRAIN, IDLE.
REQ-031 Timeout: TIMEOUT=8, read with no ack -> cyc/stb drop after 8 cycles, timeout_o single pulse, EM_D_o=16'hDEAD, EM_WAIT0 high.
REQ-032 Ack on timeout boundary cycle -> no timeout_o, data from wb_dat_i.
REQ-033 Second NWE pulse during WR_REQ (ack held off) -> exactly one WB write issued; NWE and NOE both low in IDLE -> no WB cycle.
REQ-034 rst_fpga asserted in RD_REQ with NOE held low -> all outputs at reset values; after release, no read until NOE toggles high then low.
